icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the CPU's instruction-fetch path (PC / request unit) and the shared request_ram port.
- Hits return the instruction combinationally in the same cycle.
- Misses run a single-word fill from RAM using the req/busy handshake, then present the word to the CPU.
- Lets the request unit skip RAM arbitration on repeated fetches; no D-side traffic passes through this block.

---
 rtl/icache_dm_if.sv | 27 ++
 rtl/icache_dm.sv | 151 +++++++++++++++
 tb/tb_icache_dm.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// Signal bundle for icache_dm: CPU fetch port, RAM fill port, flush and statistics.
// The cache takes the slave view; the fetch unit and RAM side take the master view.
interface icache_dm_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_instr;
    logic              cpu_ready;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_busy;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    modport master (
        output cpu_req, cpu_addr, flush, mem_rdata, mem_busy,
        input  cpu_instr, cpu_ready, mem_req, mem_addr, hit_count, miss_count
    );

    modport slave (
        input  cpu_req, cpu_addr, flush, mem_rdata, mem_busy,
        output cpu_instr, cpu_ready, mem_req, mem_addr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line read-only instruction cache with single-word RAM fill.
// Optional saturating hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_dm #(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    icache_dm_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [31:0]          data_r [NUM_LINES];
    logic [ADDR_W-3:0]    laddr_r;
    logic [31:0]          hold_r;
    logic                 busy_seen_r;
    logic                 flush_pend_r;

    logic [IDX_W-1:0]     idx_s;
    logic [TAG_W-1:0]     tag_s;
    logic [IDX_W-1:0]     fill_idx_s;
    logic [TAG_W-1:0]     fill_tag_s;
    logic                 hit_s;
    logic                 miss_s;
    logic                 fill_s;
    logic                 unused_s;

    assign idx_s      = bus.cpu_addr[IDX_W+1:2];
    assign tag_s      = bus.cpu_addr[ADDR_W-1:IDX_W+2];
    assign fill_idx_s = laddr_r[IDX_W-1:0];
    assign fill_tag_s = laddr_r[ADDR_W-3:IDX_W];
    assign unused_s   = ^bus.cpu_addr[1:0];

    assign bus.mem_req  = (state_r == ISSUE);
    assign bus.mem_addr = {laddr_r, 2'b00};

    // Next-state decode, hit detection and CPU-side response
    always_comb begin
        state_nxt_s   = state_r;
        hit_s         = 1'b0;
        miss_s        = 1'b0;
        fill_s        = 1'b0;
        bus.cpu_ready = 1'b0;
        bus.cpu_instr = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                hit_s = bus.cpu_req & valid_r[idx_s] & (tag_r[idx_s] == tag_s);
                if (hit_s) begin
                    bus.cpu_ready = 1'b1;
                    bus.cpu_instr = data_r[idx_s];
                end else if (bus.cpu_req) begin
                    miss_s      = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                // Completion needs a busy high phase first, so a stale low level is not taken as data
                if (!bus.mem_busy && busy_seen_r) begin
                    fill_s      = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (bus.cpu_req && (bus.cpu_addr[ADDR_W-1:2] == laddr_r)) begin
                    bus.cpu_ready = 1'b1;
                    bus.cpu_instr = hold_r;
                end else begin
                    bus.cpu_ready = 1'b0;
                end
                state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register, miss bookkeeping and line valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            valid_r      <= '0;
            laddr_r      <= '0;
            hold_r       <= 32'h0000_0000;
            busy_seen_r  <= 1'b0;
            flush_pend_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (miss_s) begin
                laddr_r      <= bus.cpu_addr[ADDR_W-1:2];
                busy_seen_r  <= 1'b0;
                flush_pend_r <= 1'b0;
            end else begin
                if (state_r == WAIT && bus.mem_busy) busy_seen_r <= 1'b1;
                if ((state_r == ISSUE || state_r == WAIT) && bus.flush) flush_pend_r <= 1'b1;
            end
            if (fill_s) hold_r <= bus.mem_rdata;
            // A flush seen anywhere in the fill leaves the new line invalid
            if (bus.flush) begin
                valid_r <= '0;
            end else if (fill_s) begin
                valid_r[fill_idx_s] <= ~flush_pend_r;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them
    always_ff @(posedge clk) begin
        if (fill_s && !rst) begin
            tag_r[fill_idx_s]  <= fill_tag_s;
            data_r[fill_idx_s] <= bus.mem_rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Saturating statistics counters, cleared by reset only
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r  <= 32'h0000_0000;
            miss_cnt_r <= 32'h0000_0000;
        end else begin
            if (hit_s && hit_cnt_r != 32'hFFFF_FFFF) hit_cnt_r <= hit_cnt_r + 32'd1;
            if (miss_s && miss_cnt_r != 32'hFFFF_FFFF) miss_cnt_r <= miss_cnt_r + 32'd1;
        end
    end

    assign bus.hit_count  = hit_cnt_r;
    assign bus.miss_count = miss_cnt_r;
`else
    assign bus.hit_count  = 32'h0000_0000;
    assign bus.miss_count = 32'h0000_0000;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: a line-table reference model predicts hit/miss, a RAM
// responder serves fills, and monitors compare every CPU response and RAM request.
module tb_icache_dm;
    localparam int NL = 16;

    logic clk = 1'b0;
    logic rst;
    icache_dm_if #(.ADDR_W(32)) bus ();

    icache_dm #(.NUM_LINES(NL), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ram [256];
    bit          mv  [NL];
    logic [29:0] mwa [NL];
    logic [31:0] expq [$];
    logic [31:0] memq [$];
    int          ram_lat = 3;
    bit          ram_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        logic [3:0] i;
        i = a[5:2];
        return mv[i] && (mwa[i] == a[31:2]);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NL; k++) mv[k] = 1'b0;
    endtask

    // CPU-side monitor: every ready pops one expected word; no ready means instr 0
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.cpu_ready) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got instr %h expected no response", bus.cpu_instr);
                end else begin
                    check("cpu_instr", bus.cpu_instr, expq.pop_front());
                end
            end else begin
                check("instr_zero", bus.cpu_instr, 32'h0);
            end
            if (bus.mem_req) begin
                if (memq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: got addr %h expected no request", bus.mem_addr);
                end else begin
                    check("mem_addr", bus.mem_addr, memq.pop_front());
                end
            end
        end
    end

    // RAM responder: busy rises the cycle after mem_req, stays high ram_lat cycles
    initial begin
        logic [31:0] ra;
        bus.mem_busy  = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !rst) begin
                ra = bus.mem_addr;
                ram_active = 1'b1;
                @(posedge clk); #1 bus.mem_busy = 1'b1;
                repeat (ram_lat - 1) @(posedge clk);
                @(posedge clk); #1;
                bus.mem_busy  = 1'b0;
                bus.mem_rdata = ram[ra[9:2]];
                @(posedge clk); #1 bus.mem_rdata = $urandom;
                ram_active = 1'b0;
            end
        end
    end

    // mode 0: plain, 1: flush in the request cycle, 2: flush pulse during the RAM wait
    task automatic fetch(input logic [31:0] a, input int mode);
        logic [3:0] i;
        bit         h;
        bit         done_flush;
        int         t;
        i = a[5:2];
        h = model_hit(a);
        expq.push_back(ram[a[9:2]]);
        if (!h) memq.push_back({a[31:2], 2'b00});
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        bus.flush    = (mode == 1);
        @(negedge clk);
        if (h) begin
            if (mode == 1) model_clear();
        end else begin
            t = 0;
            done_flush = 1'b0;
            while (!bus.cpu_ready && t < 60) begin
                @(posedge clk); #1 bus.flush = 1'b0;
                @(negedge clk);
                t++;
                if (mode == 2 && bus.mem_busy && !done_flush) begin
                    bus.flush  = 1'b1;
                    done_flush = 1'b1;
                end
            end
            if (t >= 60) fail_now("miss_timeout");
            else check("miss_latency", t, ram_lat + 3);
            if (mode != 0) model_clear();
            mv[i]  = (mode != 2);
            mwa[i] = a[31:2];
        end
    endtask

    // Miss on a, move the fetch address to b while the fill is outstanding
    task automatic miss_change(input logic [31:0] a, input logic [31:0] b);
        logic [3:0] ia;
        logic [3:0] ib;
        int         t;
        ia = a[5:2];
        ib = b[5:2];
        memq.push_back({a[31:2], 2'b00});
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        bus.flush    = 1'b0;
        t = 0;
        @(negedge clk);
        while (!bus.mem_busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) fail_now("busy_timeout");
        bus.cpu_addr = b;
        mv[ia]  = 1'b1;
        mwa[ia] = a[31:2];
        expq.push_back(ram[b[9:2]]);
        if (!model_hit(b)) memq.push_back({b[31:2], 2'b00});
        t = 0;
        while (!bus.cpu_ready && t < 80) begin
            @(negedge clk);
            t++;
        end
        if (t >= 80) fail_now("change_timeout");
        mv[ib]  = 1'b1;
        mwa[ib] = b[31:2];
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        bus.flush   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    task automatic reset_midfill(input logic [31:0] a);
        int t;
        ram_lat = 6;
        memq.push_back({a[31:2], 2'b00});
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        bus.flush    = 1'b0;
        t = 0;
        @(negedge clk);
        while (!bus.mem_busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        do_reset();
        t = 0;
        while (ram_active && t < 60) begin
            @(posedge clk);
            t++;
        end
        if (t >= 60) fail_now("ram_idle_timeout");
        repeat (2) @(posedge clk);
        ram_lat = 3;
    endtask

    task automatic flush_pulse();
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        bus.flush   = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        model_clear();
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = $urandom;
        bus.flush    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          r;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          r;
        rst = 1'b1;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = 32'h0;
        bus.flush    = 1'b0;
        for (int k = 0; k < 256; k++) ram[k] = $urandom;
        ram[8'h10] = 32'h0010_0093;

        do_reset();
        @(negedge clk);
        check("rst_ready", {31'h0, bus.cpu_ready}, 32'h0);
        check("rst_instr", bus.cpu_instr, 32'h0);
        check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_hit_count", bus.hit_count, 32'h0);
        check("rst_miss_count", bus.miss_count, 32'h0);

        ram_lat = 3;
        fetch(32'h40, 0);
        fetch(32'h40, 0);
        fetch(32'h80, 0);
        fetch(32'h40, 0);
        flush_pulse();
        fetch(32'h40, 0);
        flush_pulse();
        fetch(32'h40, 2);
        fetch(32'h40, 0);
        fetch(32'h40, 1);
        fetch(32'h40, 0);
        miss_change(32'h44, 32'h48);
        fetch(32'h44, 0);
        reset_midfill(32'h100);
        fetch(32'h100, 0);

        for (int n = 0; n < 150; n++) begin
            ra = $urandom_range(0, 255);
            ram_lat = $urandom_range(1, 4);
            r = $urandom_range(0, 19);
            if (r == 0) begin
                idle_cycle();
            end else if (r == 1 && !model_hit(ra)) begin
                rb = $urandom_range(0, 255);
                if (rb[5:2] != ra[5:2]) miss_change(ra, rb);
                else fetch(ra, 0);
            end else begin
                fetch(ra, (r == 2) ? 1 : ((r == 3) ? 2 : 0));
            end
        end

        ram_lat = 3;
        do_reset();
        fetch(32'h40, 0);
        repeat (3) fetch(32'h40, 0);
        @(posedge clk); #1 bus.cpu_req = 1'b0;
        @(negedge clk);
`ifdef ICACHE_STATS_EN
        check("hit_count", bus.hit_count, 32'd3);
        check("miss_count", bus.miss_count, 32'd1);
`else
        check("hit_count", bus.hit_count, 32'd0);
        check("miss_count", bus.miss_count, 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("expq_left", expq.size(), 32'd0);
        check("memq_left", memq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
